frame_read_sequencer: RTL and testbench

//  Sequences one or more frames of pixels out of a frame memory into the pixel stream.

---
 rtl/pixel_ctrl_pkg.sv | 17 +
 rtl/pix_skid_buffer.sv | 57 +++++
 rtl/frame_read_sequencer.sv | 176 +++++++++++++++++
 tb/tb_frame_read_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default dimensions for the frame read sequencer and its output stage.
package pixel_ctrl_pkg;

    localparam int H_PIX_DEF   = 9;
    localparam int V_PIX_DEF   = 9;
    localparam int DATA_W_DEF  = 8;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_DRAIN,
        ST_VBLANK
    } seqState_t;

endpackage

// File: rtl/pix_skid_buffer.sv
// Registered output stage with a one-entry skid so upstream data arriving during a stall is kept.
module pix_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        fill_o
);

    logic              outValid_q;
    logic [DATA_W-1:0] outData_q;
    logic              skidValid_q;
    logic [DATA_W-1:0] skidData_q;
    logic              loadOut;

    assign loadOut     = !outValid_q || out_ready_i;
    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign fill_o      = {1'b0, outValid_q} + {1'b0, skidValid_q};

    // The skid always holds the older pixel, so it refills the output register first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
        end else if (flush_i) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
        end else if (loadOut) begin
            if (skidValid_q) begin
                outValid_q  <= 1'b1;
                outData_q   <= skidData_q;
                skidValid_q <= in_valid_i;
                if (in_valid_i) begin
                    skidData_q <= in_data_i;
                end
            end else begin
                outValid_q <= in_valid_i;
                if (in_valid_i) begin
                    outData_q <= in_data_i;
                end
            end
        end else if (in_valid_i && !skidValid_q) begin
            skidValid_q <= 1'b1;
            skidData_q  <= in_data_i;
        end
    end

endmodule

// File: rtl/frame_read_sequencer.sv
// Raster-order frame reader feeding a valid/ready pixel stream; define BLANK_EN to insert
// HBLANK/VBLANK idle cycles, otherwise lines and continuous frames run back to back.
module frame_read_sequencer
    import pixel_ctrl_pkg::*;
#(
    parameter int H_PIX  = H_PIX_DEF,
    parameter int V_PIX  = V_PIX_DEF,
    parameter int ADDR_W = 7,
    parameter int DATA_W = DATA_W_DEF,
    parameter int HBLANK = 2,
    parameter int VBLANK = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   cont_i,
    output logic                   mem_rd_en_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic [DATA_W-1:0]      mem_rd_data_i,
    input  logic                   pix_ready_i,
    output logic                   pix_valid_o,
    output logic [DATA_W-1:0]      pix_data_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

`ifdef BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    localparam int HB_CYC    = BLANK_ON ? HBLANK : 0;
    localparam int VB_CYC    = BLANK_ON ? VBLANK : 0;
    localparam int BLANK_MAX = (HB_CYC > VB_CYC) ? HB_CYC : VB_CYC;
    localparam int BLANK_W   = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;
    localparam int HCNT_W    = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int VCNT_W    = (V_PIX > 1) ? $clog2(V_PIX) : 1;

    seqState_t              state_q;
    logic [HCNT_W-1:0]      hCnt_q;
    logic [VCNT_W-1:0]      vCnt_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [BLANK_W-1:0]     blankCnt_q;
    logic                   inflight_q;
    logic                   frameDone_q;
    logic [FRAME_CNT_W-1:0] frameCnt_q;
    logic [FRAME_CNT_W-1:0] frameCnt_d;

    logic [1:0] bufFill;
    logic [1:0] pending;
    logic       xfer;
    logic       creditOk;
    logic       rdEn;
    logic       lastPix;
    logic       lastLine;
    logic       pipeEmpty;

    // Pixels owed to the output: one possible read in flight plus whatever the buffers hold.
    assign pending   = {1'b0, inflight_q} + bufFill;
    assign xfer      = pix_valid_o && pix_ready_i;
    assign creditOk  = (pending < 2'd2) || ((pending == 2'd2) && xfer);
    assign rdEn      = (state_q == ST_ACTIVE) && !abort_i && creditOk;
    assign lastPix   = (hCnt_q == HCNT_W'(H_PIX - 1));
    assign lastLine  = (vCnt_q == VCNT_W'(V_PIX - 1));
    assign pipeEmpty = !inflight_q && (bufFill == 2'd0);
    assign frameCnt_d = frameCnt_q + 1'b1;

    assign mem_rd_en_o  = rdEn;
    assign mem_addr_o   = addr_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frameDone_q;
    assign frame_cnt_o  = frameCnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hCnt_q      <= '0;
            vCnt_q      <= '0;
            addr_q      <= '0;
            blankCnt_q  <= '0;
            inflight_q  <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= '0;
        end else if (abort_i) begin
            state_q     <= ST_IDLE;
            hCnt_q      <= '0;
            vCnt_q      <= '0;
            addr_q      <= '0;
            blankCnt_q  <= '0;
            inflight_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            inflight_q  <= rdEn;
            frameDone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_ACTIVE;
                        addr_q  <= '0;
                        hCnt_q  <= '0;
                        vCnt_q  <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (rdEn) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (lastPix) begin
                            hCnt_q <= '0;
                            if (lastLine) begin
                                vCnt_q  <= '0;
                                state_q <= ST_DRAIN;
                            end else begin
                                vCnt_q <= vCnt_q + VCNT_W'(1);
                                if (HB_CYC > 0) begin
                                    state_q    <= ST_HBLANK;
                                    blankCnt_q <= '0;
                                end
                            end
                        end else begin
                            hCnt_q <= hCnt_q + HCNT_W'(1);
                        end
                    end
                end
                ST_HBLANK: begin
                    if (blankCnt_q == BLANK_W'(HB_CYC - 1)) begin
                        state_q <= ST_ACTIVE;
                    end else begin
                        blankCnt_q <= blankCnt_q + BLANK_W'(1);
                    end
                end
                // The next frame may only start reading once this frame's last pixel has left.
                ST_DRAIN: begin
                    if (pipeEmpty) begin
                        frameDone_q <= 1'b1;
                        frameCnt_q  <= frameCnt_d;
                        addr_q      <= '0;
                        if (!cont_i) begin
                            state_q <= ST_IDLE;
                        end else if (VB_CYC > 0) begin
                            state_q    <= ST_VBLANK;
                            blankCnt_q <= '0;
                        end else begin
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_VBLANK: begin
                    if (blankCnt_q == BLANK_W'(VB_CYC - 1)) begin
                        state_q <= ST_ACTIVE;
                    end else begin
                        blankCnt_q <= blankCnt_q + BLANK_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pix_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_outStage (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (abort_i),
        .in_valid_i  (inflight_q),
        .in_data_i   (mem_rd_data_i),
        .out_valid_o (pix_valid_o),
        .out_data_o  (pix_data_o),
        .out_ready_i (pix_ready_i),
        .fill_o      (bufFill)
    );

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Self-checking bench for frame_read_sequencer: random frame memory, scoreboard of expected pixels,
// directed scenarios for start/abort/continuous mode; expected blanking follows BLANK_EN.
module tb_frame_read_sequencer;

    localparam int H_PIX = 9;
    localparam int V_PIX = 9;
    localparam int NPIX  = H_PIX * V_PIX;
`ifdef BLANK_EN
    localparam int HB_EXP = 2;
    localparam int VB_EXP = 4;
`else
    localparam int HB_EXP = 0;
    localparam int VB_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cont = 1'b0;
    logic       pixReady = 1'b0;
    logic       memRdEn;
    logic [6:0] memAddr;
    logic [7:0] memRdData = 8'h00;
    logic       pixValid;
    logic [7:0] pixData;
    logic       busy;
    logic       frameDone;
    logic [7:0] frameCnt;

    logic [7:0] mem [0:127];
    logic [7:0] expQ [$];
    int total = 0;
    int bad = 0;
    int readyMode = 0;
    bit gapCheckEn = 1'b0;
    int expAddr = 0;
    int acceptedInFrame = 0;
    logic [7:0] expCnt = 8'h00;
    int doneSeen = 0;
    int cyc = 0;
    int lastReadCyc = 0;
    int lastReadAddr = -1;
    bit prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;

    frame_read_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_i       (start),
        .abort_i       (abort),
        .cont_i        (cont),
        .mem_rd_en_o   (memRdEn),
        .mem_addr_o    (memAddr),
        .mem_rd_data_i (memRdData),
        .pix_ready_i   (pixReady),
        .pix_valid_o   (pixValid),
        .pix_data_o    (pixData),
        .busy_o        (busy),
        .frame_done_o  (frameDone),
        .frame_cnt_o   (frameCnt)
    );

    always #5 clk = ~clk;

    // Synchronous frame memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (memRdEn) memRdData <= mem[memAddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs just after the rising edge; return just after the falling edge.
    task automatic applyStimulus(input logic s, input logic a, input logic c);
        @(posedge clk);
        #1;
        start = s;
        abort = a;
        cont = c;
        pixReady = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic stepCycle();
        applyStimulus(1'b0, 1'b0, cont);
    endtask

    task automatic waitRead(input int limit);
        int n = 0;
        do begin
            stepCycle();
            n++;
        end while (memRdEn !== 1'b1 && n < limit);
        checkOutput("readTimeout", 32'(memRdEn), 1);
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        do begin
            stepCycle();
            n++;
        end while (frameDone !== 1'b1 && n < limit);
        checkOutput("doneTimeout", 32'(frameDone), 1);
    endtask

    // Reference model: every read queues the memory word at the next raster address,
    // every accepted pixel must be the oldest queued word.
    always @(negedge clk) begin
        int outs;
        int gap;
        bit xfer;
        if (!reset_n) begin
            expQ.delete();
            expAddr = 0;
            acceptedInFrame = 0;
            expCnt = 8'h00;
            prevStall = 1'b0;
            lastReadAddr = -1;
        end else begin
            cyc++;
            xfer = pixValid && pixReady;
            outs = expQ.size();
            if (prevStall) begin
                checkOutput("holdValid", 32'(pixValid), 1);
                checkOutput("holdData", 32'(pixData), 32'(prevData));
            end
            if (frameDone === 1'b1) begin
                checkOutput("doneAfterAll", acceptedInFrame, NPIX);
                acceptedInFrame = 0;
                expCnt = expCnt + 8'd1;
                doneSeen++;
            end
            checkOutput("frameCnt", 32'(frameCnt), 32'(expCnt));
            if (xfer) begin
                if (outs == 0) checkOutput("spuriousPixel", 32'(pixData), 32'hFFFF_FFFF);
                else checkOutput("pixData", 32'(pixData), 32'(expQ.pop_front()));
                acceptedInFrame++;
            end
            if (memRdEn === 1'b1) begin
                checkOutput("credit", ((outs < 2) || (outs == 2 && xfer)) ? 1 : 0, 1);
                checkOutput("rdAddr", 32'(memAddr), expAddr);
                if (expAddr == 0) checkOutput("drainedBeforeNext", outs, 0);
                if (gapCheckEn && lastReadAddr >= 0) begin
                    gap = cyc - lastReadCyc - 1;
                    if (expAddr == 0)
                        checkOutput("frameGap", (gap >= VB_EXP + 2 && gap <= VB_EXP + 4) ? 1 : 0, 1);
                    else if (expAddr % H_PIX == 0)
                        checkOutput("lineGap", gap, HB_EXP);
                    else
                        checkOutput("pixGap", gap, 0);
                end
                expQ.push_back(mem[expAddr]);
                lastReadAddr = expAddr;
                lastReadCyc = cyc;
                expAddr = (expAddr == NPIX - 1) ? 0 : expAddr + 1;
            end
            if (abort) begin
                expQ.delete();
                expAddr = 0;
                acceptedInFrame = 0;
                prevStall = 1'b0;
            end else begin
                prevStall = pixValid && !pixReady;
                prevData = pixData;
            end
        end
    end

    initial begin
        int n;
        int doneBefore;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstRdEn", 32'(memRdEn), 0);
        checkOutput("rstAddr", 32'(memAddr), 0);
        checkOutput("rstValid", 32'(pixValid), 0);
        checkOutput("rstData", 32'(pixData), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(frameDone), 0);
        checkOutput("rstCnt", 32'(frameCnt), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;

        // Single frame, always ready: latency and full frame
        $display("[TB] single frame, ready=1");
        readyMode = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitRead(5);
        checkOutput("firstAddr", 32'(memAddr), 0);
        gapCheckEn = 1'b1;
        stepCycle();
        checkOutput("latency1", 32'(pixValid), 0);
        stepCycle();
        checkOutput("latency2Valid", 32'(pixValid), 1);
        checkOutput("latency2Data", 32'(pixData), 32'(mem[0]));
        waitDone(300);
        gapCheckEn = 1'b0;
        checkOutput("cntAfter1", 32'(frameCnt), 1);
        repeat (3) stepCycle();
        checkOutput("idleAfter1", 32'(busy), 0);

        // start and abort together, then start while busy
        $display("[TB] start+abort, start while active");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) stepCycle();
        checkOutput("startAbortBusy", 32'(busy), 0);
        checkOutput("startAbortRd", 32'(memRdEn), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(300);
        checkOutput("cntAfterDoubleStart", 32'(frameCnt), 2);

        // Random backpressure
        $display("[TB] random backpressure");
        readyMode = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1500);
        checkOutput("cntAfterRandom", 32'(frameCnt), 3);

        // Abort during line 4 with the output stalled and both buffer slots full
        $display("[TB] abort mid-frame");
        readyMode = 0;
        repeat (3) stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!(memRdEn === 1'b1 && memAddr >= 7'd38) && n < 100);
        checkOutput("reachLine4", 32'(memRdEn), 1);
        readyMode = 2;
        repeat (3) stepCycle();
        checkOutput("bufferedBeforeAbort", expQ.size(), 2);
        doneBefore = doneSeen;
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortValid", 32'(pixValid), 0);
        checkOutput("abortRdEn", 32'(memRdEn), 0);
        readyMode = 0;
        repeat (10) stepCycle();
        checkOutput("noDoneAfterAbort", doneSeen - doneBefore, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitRead(5);
        checkOutput("restartAddr", 32'(memAddr), 0);
        // Abort again while a read is in flight, then a clean frame
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!(memRdEn === 1'b1 && memAddr >= 7'd20) && n < 100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("abort2Busy", 32'(busy), 0);
        checkOutput("abort2Valid", 32'(pixValid), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(300);
        checkOutput("cntAfterAbort", 32'(frameCnt), 4);

        // Continuous mode until the frame counter wraps
        $display("[TB] continuous mode to counter wrap");
        repeat (3) stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitRead(5);
        gapCheckEn = 1'b1;
        n = 0;
        do begin
            waitDone(400);
            n++;
        end while (frameCnt !== 8'd0 && n < 300);
        checkOutput("cntWrap", 32'(frameCnt), 0);
        checkOutput("doneTotal", doneSeen, 256);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDone(400);
        gapCheckEn = 1'b0;
        repeat (3) stepCycle();
        checkOutput("contStopBusy", 32'(busy), 0);
        checkOutput("contStopRd", 32'(memRdEn), 0);
        checkOutput("cntFinal", 32'(frameCnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
